// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: run-control and performance monitor for riscv_pipeline.
// Counts cycles, stalls, flushes and retired writebacks while in RUN, stops on
// a cycle-limit watchdog or after a quiet stretch with no retirements, and
// records retired writebacks into a first-word-fall-through trace FIFO.
// Optional macro PERF_TRACE_OVERWRITE_EN: a push into a full FIFO evicts the
// oldest entry instead of being dropped.
module pipeline_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 8,
  parameter int MAX_CYCLES  = 50,
  parameter int QUIET_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             trace_pop,
  output logic             trace_valid,
  output logic [4:0]       trace_rd,
  output logic [XLEN-1:0]  trace_data,
  output logic             trace_overflow,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [1:0]       state,
  output logic             done,
  output logic             timeout
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int QW = $clog2(QUIET_LIMIT + 1);
  localparam int EW = 5 + XLEN;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  state_t state_reg, state_next;

  logic in_run;
  logic retire;
  logic push;

  assign in_run = (state_reg == ST_RUN);
  // Writes to x0 are architecturally invisible, so they do not retire.
  assign retire = wb_valid && (wb_rd != 5'd0);
  assign push   = in_run && retire;

  // ---------------------------------------------------------------- counters
  // Index 0 cycle, 1 stall, 2 flush, 3 retire.
  logic [3:0]            cnt_event;
  logic [3:0][CNT_W-1:0] cnt_val;

  assign cnt_event = {retire, flush_in, stall_in, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      // Saturating event counter, active only while running.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (in_run && cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign cycle_cnt  = cnt_val[0];
  assign stall_cnt  = cnt_val[1];
  assign flush_cnt  = cnt_val[2];
  assign retire_cnt = cnt_val[3];

  // Watchdog fires on the cycle whose increment lands on MAX_CYCLES.
  logic [CNT_W-1:0] cycle_inc;
  logic             hit_max;

  assign cycle_inc = (cnt_val[0] == {CNT_W{1'b1}}) ? cnt_val[0] : cnt_val[0] + 1'b1;
  assign hit_max   = in_run && (cycle_inc == CNT_W'(MAX_CYCLES));

  // ------------------------------------------------------------ quiet counter
  logic [QW-1:0] quiet_reg;
  logic          quiet_hit;

  // While running, quiet_reg never exceeds QUIET_LIMIT-1, so +1 cannot overflow.
  assign quiet_hit = in_run && !retire && ((quiet_reg + 1'b1) == QW'(QUIET_LIMIT));

  // Counts consecutive non-retiring RUN cycles; restarts on retire or run start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_reg <= '0;
    end else if (clear) begin
      quiet_reg <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      quiet_reg <= '0;
    end else if (in_run) begin
      quiet_reg <= retire ? '0 : quiet_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------- FSM
  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else if (clear) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; timeout takes precedence over done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (hit_max)        state_next = ST_TIMEOUT;
        else if (quiet_hit) state_next = ST_DONE;
      end
      default:    state_next = state_reg;
    endcase
  end

  assign state   = state_reg;
  assign done    = (state_reg == ST_DONE);
  assign timeout = (state_reg == ST_TIMEOUT);

  // --------------------------------------------------------------- trace FIFO
  logic [EW-1:0] mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic          full, empty, pop, lost, wr_en, evict, rd_adv;
  logic [EW-1:0] head;

  assign full  = (count_reg == (AW+1)'(TRACE_DEPTH));
  assign empty = (count_reg == '0);
  assign pop   = trace_pop && !empty;
  // A push into a full FIFO with no pop to make room loses an entry somewhere.
  assign lost  = push && full && !pop;

`ifdef PERF_TRACE_OVERWRITE_EN
  assign wr_en = push;
  assign evict = lost;
`else
  assign wr_en = push && (!full || pop);
  assign evict = 1'b0;
`endif

  assign rd_adv = pop || evict;

  // Pointer, occupancy and sticky overflow tracking; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !rd_adv)      count_reg <= count_reg + 1'b1;
      else if (!wr_en && rd_adv) count_reg <= count_reg - 1'b1;
      if (lost) overflow_reg <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {wb_rd, wb_data};
  end

  assign head           = mem[rd_ptr_reg];
  assign trace_valid    = !empty;
  assign trace_rd       = empty ? 5'd0 : head[EW-1:XLEN];
  assign trace_data     = empty ? '0 : head[XLEN-1:0];
  assign trace_overflow = overflow_reg;

endmodule

// File: doc/pipeline_perf_monitor.md
Name: pipeline_perf_monitor

Overview:
- Synthesizable run-control and performance monitor attached beside the riscv_pipeline core.
- Replaces simulation-only cycle counting and printing with hardware counters for cycles, stalls, flushes and retired writebacks.
- Adds a cycle-limit watchdog, end-of-program detection, and a parametrised writeback trace FIFO that software or a bench drains through a valid/pop handshake.

Parameters:
- CNT_W, 32: width of every event counter.
- XLEN, 32: writeback data width.
- TRACE_DEPTH, 8: trace FIFO entries; power of two, at least 2.
- MAX_CYCLES, 50: watchdog limit in cycles; at least 1, fits in CNT_W.
- QUIET_LIMIT, 8: consecutive non-retiring RUN cycles that mark the end of the program; at least 1.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a run from IDLE
- clear  in  1  synchronous clear of counters, FIFO and FSM
- stall_in  in  1  pipeline stall this cycle (~PCWrite)
- flush_in  in  1  IF/ID flush this cycle
- wb_valid  in  1  writeback stage is writing the register file
- wb_rd  in  5  writeback destination register
- wb_data  in  XLEN  writeback value
- trace_pop  in  1  consume the head trace entry
- trace_valid  out  1  FIFO not empty
- trace_rd  out  5  head entry destination register
- trace_data  out  XLEN  head entry value
- trace_overflow  out  1  sticky; a push was lost or overwrote an entry
- cycle_cnt, stall_cnt, flush_cnt, retire_cnt  out  CNT_W each  event counters
- state  out  2  00 IDLE, 01 RUN, 10 DONE, 11 TIMEOUT
- done  out  1  state == DONE
- timeout  out  1  state == TIMEOUT

Behaviour:
- Reset (async) and clear (sync) have the same effect:
  - state IDLE; all counters 0; FIFO empty; trace_overflow 0.
  - trace_rd and trace_data read 0 while the FIFO is empty.
  - clear has priority over start and over all events in the same cycle.
- FSM:
  - IDLE -> RUN on start.
  - RUN -> TIMEOUT when cycle_cnt would reach MAX_CYCLES on this cycle's increment. TIMEOUT wins over DONE if both conditions occur together.
  - RUN -> DONE when the quiet counter reaches QUIET_LIMIT.
  - DONE and TIMEOUT hold until clear or reset.
  - start outside IDLE is ignored.
- Counting (RUN state only; the cycle that exits RUN still counts):
  - cycle_cnt +1 every cycle.
  - stall_cnt +1 when stall_in.
  - flush_cnt +1 when flush_in.
  - retire_cnt +1 when wb_valid && wb_rd != 0.
  - All counters saturate at all-ones and never wrap.
- Quiet counter (internal):
  - Reset to 0 on any retirement or on IDLE -> RUN.
  - Otherwise +1 per RUN cycle.
- Trace FIFO:
  - Push on a retirement in RUN, storing {wb_rd, wb_data}.
  - Pop when trace_pop && trace_valid. Popping while empty is a no-op.
  - Outputs are first-word-fall-through: an entry is visible the cycle after its push.
  - Push and pop together while full both succeed; occupancy is unchanged and there is no overflow.
  - Push and pop together while empty: the entry appears next cycle.
  - Pointers wrap modulo TRACE_DEPTH.
  - Pops are still accepted in DONE and TIMEOUT; no pushes occur there.
- Latency: every counter and state update is visible one cycle after the triggering input edge.

Optional Feature:
- Macro: PERF_TRACE_OVERWRITE_EN.
- Defined: a push into a full FIFO, with no pop that cycle, overwrites the oldest entry by advancing the read pointer. trace_overflow sets. The newest TRACE_DEPTH entries are retained.
- Undefined: the push is dropped, the FIFO contents are unchanged, and trace_overflow sets.

Test Plan:
- Reset mid-run:
  - Stimulus: start, run 5 retirements, assert reset for 1 cycle.
  - Required: state=00, all counters 0, trace_valid=0, asynchronously.
- Normal run:
  - Stimulus: start; retire x1=7, x2=7, x3=0, then idle 8 cycles; stall_in high 2 cycles, flush_in high 1 cycle.
  - Required: state DONE at cycle 11, retire_cnt=3, stall_cnt=2, flush_cnt=1. Pops return (1,7), (2,7), (3,0) in order.
- Watchdog:
  - Stimulus: start with one retirement every cycle.
  - Required: TIMEOUT entered with cycle_cnt=50, done=0, timeout=1. Further activity changes nothing.
- x0 filter:
  - Stimulus: wb_valid with wb_rd=0.
  - Required: no retire_cnt increment, no push, quiet counter keeps counting.
- FIFO full:
  - Stimulus: 9 retirements, no pops, TRACE_DEPTH=8.
  - Required without the macro: trace_overflow=1; head is entry 1, last pop is entry 8.
  - Required with the macro: head is entry 2, last pop is entry 9.
  - Also: simultaneous push and pop while full gives no overflow.
- Saturation:
  - Stimulus: CNT_W=4, MAX_CYCLES=15, constant stall.
  - Required: stall_cnt stops at 15, no wrap; timeout asserts.
